// File: rtl/l1c_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the L1 I-cache and D-cache.
// Optional grant/contention counters are built only when L1C_ARB_PERF_EN is defined.
module l1c_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              I_write,
  input  logic [DATA_W-1:0] I_in,
  input  logic [TYPE_W-1:0] I_type,
  output logic [DATA_W-1:0] I_out,
  output logic              I_wait,
  input  logic              D_req,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic              D_write,
  input  logic [DATA_W-1:0] D_in,
  input  logic [TYPE_W-1:0] D_type,
  output logic [DATA_W-1:0] D_out,
  output logic              D_wait,
  output logic              M_req,
  output logic [ADDR_W-1:0] M_addr,
  output logic              M_write,
  output logic [DATA_W-1:0] M_in,
  output logic [TYPE_W-1:0] M_type,
  input  logic [DATA_W-1:0] M_out,
  input  logic              M_wait,
  output logic [CNT_W-1:0]  perf_i_grants,
  output logic [CNT_W-1:0]  perf_d_grants,
  output logic [CNT_W-1:0]  perf_conflict
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e state_q;
  logic   last_d_q;   // 1 when D held the most recent grant
  logic   take_i_d;
  logic   take_d_d;

  // Arbitration decision is only made in IDLE; ties go to the side not last served.
  always_comb begin
    take_i_d = 1'b0;
    take_d_d = 1'b0;
    if (state_q == IDLE) begin
      if (I_req && D_req) begin
        if (last_d_q) take_i_d = 1'b1;
        else          take_d_d = 1'b1;
      end else if (I_req) begin
        take_i_d = 1'b1;
      end else if (D_req) begin
        take_d_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_i_d) begin
            state_q  <= GNT_I;
            last_d_q <= 1'b0;
          end else if (take_d_d) begin
            state_q  <= GNT_D;
            last_d_q <= 1'b1;
          end
        end
        // Owner keeps the port until it drops req; always pass through IDLE.
        GNT_I:   if (!I_req) state_q <= IDLE;
        GNT_D:   if (!D_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pass-through muxing keeps beat latency unchanged for the owner.
  always_comb begin
    M_req   = 1'b0;
    M_addr  = '0;
    M_write = 1'b0;
    M_in    = '0;
    M_type  = '0;
    I_out   = '0;
    I_wait  = 1'b1;
    D_out   = '0;
    D_wait  = 1'b1;
    case (state_q)
      GNT_I: begin
        M_req   = I_req;
        M_addr  = I_addr;
        M_write = I_write;
        M_in    = I_in;
        M_type  = I_type;
        I_out   = M_out;
        I_wait  = M_wait;
      end
      GNT_D: begin
        M_req   = D_req;
        M_addr  = D_addr;
        M_write = D_write;
        M_in    = D_in;
        M_type  = D_type;
        D_out   = M_out;
        D_wait  = M_wait;
      end
      default: ;
    endcase
  end

`ifdef L1C_ARB_PERF_EN
  logic [CNT_W-1:0] perf_i_q;
  logic [CNT_W-1:0] perf_d_q;
  logic [CNT_W-1:0] perf_c_q;
  logic             conflict_d;

  assign conflict_d = (state_q == IDLE) && I_req && D_req;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      if (take_i_d)   perf_i_q <= perf_i_q + 1'b1;
      if (take_d_d)   perf_d_q <= perf_d_q + 1'b1;
      if (conflict_d) perf_c_q <= perf_c_q + 1'b1;
    end
  end

  assign perf_i_grants = perf_i_q;
  assign perf_d_grants = perf_d_q;
  assign perf_conflict = perf_c_q;
`else
  assign perf_i_grants = '0;
  assign perf_d_grants = '0;
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Directed table-driven bench for l1c_mem_arbiter plus reset and round-robin sequences.
module tb_l1c_mem_arbiter;

`ifdef L1C_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int N = 0, OI = 1, OD = 2;
  localparam logic [31:0] I_IN_C   = 32'h1234_5678;
  localparam logic [2:0]  I_TYPE_C = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req, I_write, D_req, D_write, M_wait;
  logic [31:0] I_addr, I_in, D_addr, D_in, M_out;
  logic [2:0]  I_type, D_type;
  logic [31:0] I_out, D_out, M_addr, M_in;
  logic        I_wait, D_wait, M_req, M_write;
  logic [2:0]  M_type;
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflict;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  l1c_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait),
    .M_req(M_req), .M_addr(M_addr), .M_write(M_write), .M_in(M_in), .M_type(M_type),
    .M_out(M_out), .M_wait(M_wait),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_conflict(perf_conflict)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        iw;
    logic        dr;
    logic [31:0] da;
    logic        dw;
    logic [31:0] din;
    logic [2:0]  dt;
    logic        mw;
    logic [31:0] mo;
    int          own;   // expected port owner this cycle
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic iw,
                              input logic dr, input logic [31:0] da, input logic dw,
                              input logic [31:0] din, input logic [2:0] dt,
                              input logic mw, input logic [31:0] mo, input int own);
    vec_t t;
    t.ir = ir; t.ia = ia; t.iw = iw; t.dr = dr; t.da = da; t.dw = dw;
    t.din = din; t.dt = dt; t.mw = mw; t.mo = mo; t.own = own;
    return t;
  endfunction

  // {M_req, M_addr, M_write, M_in, M_type, I_out, I_wait, D_out, D_wait}
  function automatic logic [134:0] expv(input vec_t t);
    logic [134:0] e;
    e = {1'b0, 32'h0, 1'b0, 32'h0, 3'h0, 32'h0, 1'b1, 32'h0, 1'b1};
    if (t.own == OI) e = {t.ir, t.ia, t.iw, I_IN_C, I_TYPE_C, t.mo, t.mw, 32'h0, 1'b1};
    if (t.own == OD) e = {t.dr, t.da, t.dw, t.din, t.dt, 32'h0, 1'b1, t.mo, t.mw};
    return e;
  endfunction

  function automatic logic [134:0] actv();
    return {M_req, M_addr, M_write, M_in, M_type, I_out, I_wait, D_out, D_wait};
  endfunction

  task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    I_req = t.ir; I_addr = t.ia; I_write = t.iw; I_in = I_IN_C; I_type = I_TYPE_C;
    D_req = t.dr; D_addr = t.da; D_write = t.dw; D_in = t.din; D_type = t.dt;
    M_wait = t.mw; M_out = t.mo;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 32'h100, 0, 0, 32'h200, 0, 32'h0, 3'd0, 0, 32'h0, N));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_perf(input string name, input int ei, input int ed, input int ec);
    chk({name, " perf_i"}, 135'(perf_i_grants), PERF ? 135'(ei) : 135'(0));
    chk({name, " perf_d"}, 135'(perf_d_grants), PERF ? 135'(ed) : 135'(0));
    chk({name, " perf_c"}, 135'(perf_conflict), PERF ? 135'(ec) : 135'(0));
  endtask

  // Round-robin step: drive requests, sample, and check which side owns M_addr.
  task automatic rr_step(input string name, input logic ir, input logic dr, input int own);
    logic [31:0] ea;
    @(negedge clk);
    drive(mk(ir, 32'h100, 0, dr, 32'h200, 0, 32'h0, 3'd0, 0, 32'h0, N));
    #1;
    ea = (own == OI) ? 32'h100 : (own == OD) ? 32'h200 : 32'h0;
    chk(name, 135'({M_req, M_addr}), 135'({(own == OI) ? ir : (own == OD) ? dr : 1'b0, ea}));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // single I request
    tv.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 32'h0,       3'd0, 0, 32'hCAFE_0000, N));
    tv.push_back(mk(1, 32'h100, 0, 0, 32'h0,   0, 32'h0,       3'd0, 1, 32'hCAFE_0000, N));
    tv.push_back(mk(1, 32'h100, 0, 0, 32'h0,   0, 32'h0,       3'd0, 1, 32'hCAFE_0000, OI));
    tv.push_back(mk(1, 32'h100, 0, 0, 32'h200, 0, 32'h0,       3'd0, 0, 32'hAAAA_0001, OI));
    tv.push_back(mk(0, 32'h100, 0, 0, 32'h200, 0, 32'h0,       3'd0, 0, 32'hAAAA_0001, OI));
    tv.push_back(mk(0, 32'h100, 0, 0, 32'h200, 0, 32'h0,       3'd0, 0, 32'h0,         N));
    // simultaneous requests: D wins the tie, bubble, then I
    tv.push_back(mk(1, 32'h104, 1, 1, 32'h200, 0, 32'h5555,    3'd2, 1, 32'h0,         N));
    tv.push_back(mk(1, 32'h104, 1, 1, 32'h200, 0, 32'h5555,    3'd2, 0, 32'hBBBB_0000, OD));
    tv.push_back(mk(1, 32'h104, 1, 0, 32'h200, 0, 32'h5555,    3'd2, 0, 32'hBBBB_0000, OD));
    tv.push_back(mk(1, 32'h104, 1, 0, 32'h200, 0, 32'h5555,    3'd2, 0, 32'hBBBB_0000, N));
    tv.push_back(mk(1, 32'h104, 1, 0, 32'h200, 0, 32'h5555,    3'd2, 0, 32'hCCCC_0000, OI));
    tv.push_back(mk(0, 32'h104, 0, 0, 32'h200, 0, 32'h5555,    3'd2, 0, 32'hCCCC_0000, OI));
    tv.push_back(mk(0, 32'h104, 0, 0, 32'h200, 0, 32'h0,       3'd0, 0, 32'h0,         N));
    // D 4-beat fill, I pending throughout
    tv.push_back(mk(0, 32'h108, 0, 1, 32'h300, 0, 32'h0,       3'd7, 0, 32'h0,         N));
    for (int b = 1; b <= 4; b++) begin
      tv.push_back(mk(1, 32'h108, 0, 1, 32'h300, 0, 32'h0, 3'd7, 1, 32'h0, OD));
      tv.push_back(mk(1, 32'h108, 0, 1, 32'h300, 0, 32'h0, 3'd7, 1, 32'h0, OD));
      tv.push_back(mk(1, 32'h108, 0, 1, 32'h300, 0, 32'h0, 3'd7, 0, 32'(b), OD));
    end
    tv.push_back(mk(1, 32'h108, 0, 0, 32'h300, 0, 32'h0,       3'd7, 0, 32'h0,         OD));
    tv.push_back(mk(1, 32'h108, 0, 0, 32'h300, 0, 32'h0,       3'd7, 0, 32'h0,         N));
    tv.push_back(mk(1, 32'h108, 0, 0, 32'h300, 0, 32'h0,       3'd7, 0, 32'h7777_0000, OI));
    tv.push_back(mk(0, 32'h108, 0, 0, 32'h300, 0, 32'h0,       3'd7, 0, 32'h0,         OI));
    tv.push_back(mk(0, 32'h108, 0, 0, 32'h300, 0, 32'h0,       3'd7, 0, 32'h0,         N));
    // D word write
    tv.push_back(mk(0, 32'h0, 0, 1, 32'h0001_0008, 1, 32'hDEAD_BEEF, 3'd2, 0, 32'h0, N));
    tv.push_back(mk(0, 32'h0, 0, 1, 32'h0001_0008, 1, 32'hDEAD_BEEF, 3'd2, 1, 32'h0, OD));
    tv.push_back(mk(0, 32'h0, 0, 1, 32'h0001_0008, 1, 32'hDEAD_BEEF, 3'd2, 0, 32'h0, OD));
    tv.push_back(mk(0, 32'h0, 0, 0, 32'h0001_0008, 1, 32'hDEAD_BEEF, 3'd2, 0, 32'h0, OD));
    tv.push_back(mk(0, 32'h0, 0, 0, 32'h0001_0008, 0, 32'h0,         3'd0, 0, 32'h0, N));

    do_reset();
    foreach (tv[k]) begin
      @(negedge clk);
      drive(tv[k]);
      #1;
      chk($sformatf("vec%0d", k), actv(), expv(tv[k]));
    end
    // the table left counters at: I grants 3, D grants 3, conflicts 1
    chk_perf("after table", 3, 3, 1);

    // reset during an in-flight I beat
    @(negedge clk);
    drive(mk(1, 32'h140, 0, 0, 32'h240, 0, 32'h0, 3'd0, 1, 32'h0, N));
    @(negedge clk);
    #1;
    chk("rst pre grant", actv(),
        expv(mk(1, 32'h140, 0, 0, 32'h240, 0, 32'h0, 3'd0, 1, 32'h0, OI)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 32'h140, 0, 1, 32'h240, 0, 32'h0, 3'd1, 1, 32'h0, N));
    #1;
    chk("rst idle outs", actv(),
        expv(mk(0, 32'h140, 0, 1, 32'h240, 0, 32'h0, 3'd1, 1, 32'h0, N)));
    chk_perf("rst cleared", 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst then D grant", actv(),
        expv(mk(0, 32'h140, 0, 1, 32'h240, 0, 32'h0, 3'd1, 1, 32'h0, OD)));

    // three contention rounds from reset: D, I, D
    do_reset();
    rr_step("rr c0", 1, 1, N);
    rr_step("rr D1", 1, 1, OD);
    rr_step("rr D1 rel", 1, 0, OD);
    rr_step("rr c1", 1, 1, N);
    rr_step("rr I1", 1, 1, OI);
    rr_step("rr I1 rel", 0, 1, OI);
    rr_step("rr c2", 1, 1, N);
    rr_step("rr D2", 1, 1, OD);
    rr_step("rr D2 rel", 0, 0, OD);
    rr_step("rr idle", 0, 0, N);
    chk_perf("rr counts", 1, 2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/l1c_mem_arbiter.md
Name: l1c_mem_arbiter

Overview:
- Two-requester arbiter sharing the single CPU-wrapper memory port between the L1 instruction cache (I side) and the L1 data cache (D side).
- Sits between both L1C blocks and the wrapper/AXI master.
- Grants the port to one cache and holds the grant for that cache's whole transaction, including a multi-beat line fill.
- Alternates priority round-robin on contention.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TYPE_W, 3, access-type width (CACHE_TYPE_BITS).
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- I_req  in  1  I-cache request
- I_addr  in  ADDR_W  I-cache address
- I_write  in  1  I-cache write
- I_in  in  DATA_W  I-cache write data
- I_type  in  TYPE_W  I-cache access type
- I_out  out  DATA_W  read data to I-cache
- I_wait  out  1  stall to I-cache
- D_req  in  1  D-cache request
- D_addr  in  ADDR_W  D-cache address
- D_write  in  1  D-cache write
- D_in  in  DATA_W  D-cache write data
- D_type  in  TYPE_W  D-cache access type
- D_out  out  DATA_W  read data to D-cache
- D_wait  out  1  stall to D-cache
- M_req  out  1  request to memory port
- M_addr  out  ADDR_W  address to memory port
- M_write  out  1  write to memory port
- M_in  out  DATA_W  write data to memory port
- M_type  out  TYPE_W  access type to memory port
- M_out  in  DATA_W  read data from memory port
- M_wait  in  1  memory busy; a beat completes in a cycle with M_req=1 and M_wait=0
- perf_i_grants  out  CNT_W  I grant count
- perf_d_grants  out  CNT_W  D grant count
- perf_conflict  out  CNT_W  contention count

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - last_grant = I, so D wins the first tie.
  - M_req = M_write = 0; M_addr, M_in, M_type = 0.
  - I_wait = D_wait = 1; I_out = D_out = 0.
  - All perf counters = 0.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only I_req=1 -> GNT_I.
  - Only D_req=1 -> GNT_D.
  - Both = 1 -> grant the side that is not last_grant; perf_conflict increments.
  - Neither -> stay in IDLE.
  - On entering GNT_x, last_grant <= x.
- GNT_x transitions:
  - Stay while x_req=1.
  - x_req=0 -> IDLE.
  - There is one idle cycle between consecutive grants; this bubble is required.
- Outputs in IDLE:
  - M_req=0; all M_* outputs = 0.
  - Both waits = 1; both outs = 0.
  - Arbitration latency: a request seen in IDLE reaches M_req on the next cycle.
- Outputs in GNT_x (combinational pass-through, no added latency):
  - M_req = x_req; M_addr, M_write, M_in, M_type = owner's signals.
  - x_out = M_out; x_wait = M_wait.
  - Non-owner: wait = 1, out = 0.
- Burst hold:
  - The grant is not preempted while the owner holds req, regardless of beat count, so a 4-beat line fill completes uninterrupted.
  - A non-owner request is held pending and served after release.
- Owner drops req mid-beat (M_wait=1): protocol violation; the arbiter still returns to IDLE and M_req falls.
- Reset asserted mid-grant: next cycle is IDLE with reset outputs; the in-flight beat is abandoned.

Optional Feature:
- Macro: L1C_ARB_PERF_EN.
- When defined:
  - perf_i_grants increments on each IDLE->GNT_I.
  - perf_d_grants increments on each IDLE->GNT_D.
  - perf_conflict increments on each IDLE cycle with I_req=D_req=1.
  - All three counters wrap modulo 2^CNT_W.
- When undefined: all three ports are driven constant 0 and no counter flops exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then I_req=1 only, I_addr=32'h0000_0100 -> next cycle M_req=1, M_addr=0x100; I_wait follows M_wait; D_wait=1.
- I_req and D_req rise together after reset -> D granted first; after D_req drops, one IDLE cycle, then I granted; perf_conflict=1 with PERF_EN.
- D read-miss, 4 beats with M_wait=1 for 2 cycles before each beat; I_req asserted at beat 1 -> M_addr stays D's for all 4 beats; I granted 2 cycles after D_req falls.
- Repeated contention for 3 rounds -> grants alternate D, I, D; perf_d_grants=2, perf_i_grants=1.
- D write, D_addr=0x0001_0008, D_in=0xDEAD_BEEF, D_type=word -> M_write=1, M_in=0xDEADBEEF; D_wait=0 on the M_wait=0 cycle.
- rst pulsed while in GNT_I with M_wait=1 -> next cycle M_req=0, I_wait=1, counters=0; new D_req is granted normally.
